// File: rtl/puzzle_game_ctrl.sv
// Game engine for the 2x2 sliding puzzle: captures and validates a board,
// applies blank moves, counts accepted moves and reports the game status.
module puzzle_game_ctrl #(
    parameter int unsigned CNT_W  = 8,
    parameter logic [11:0] SOLVED = 12'b000_001_010_011
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic [11:0]      board_in,
    input  logic             start,
    input  logic             quit,
    input  logic             move_valid,
    input  logic [1:0]       move_dir,
    output logic [1:0]       game_status,
    output logic [11:0]      board_out,
    output logic [CNT_W-1:0] move_count,
    output logic             move_accept,
    output logic             move_reject,
    output logic             win,
    output logic             board_err
);

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAME_INITIAL = 2'b10,
        GAMING       = 2'b01,
        WINNED       = 2'b11
    } state_t;

    state_t     state;
    logic [1:0] blank_pos;

    logic       board_ok;
    logic [1:0] zero_pos;
    logic       move_legal;
    logic [1:0] target_pos;
    logic [11:0] moved_board;
    logic [CNT_W-1:0] next_count;

    // Tile value at grid position p (pos0 lives in the top bits)
    function automatic logic [2:0] tile_at(input logic [11:0] b, input logic [1:0] p);
        case (p)
            2'd0:    return b[11:9];
            2'd1:    return b[8:6];
            2'd2:    return b[5:3];
            default: return b[2:0];
        endcase
    endfunction

    // Board with position p overwritten by tile t
    function automatic logic [11:0] set_tile(input logic [11:0] b, input logic [1:0] p,
                                             input logic [2:0] t);
        logic [11:0] r;
        r = b;
        case (p)
            2'd0:    r[11:9] = t;
            2'd1:    r[8:6]  = t;
            2'd2:    r[5:3]  = t;
            default: r[2:0]  = t;
        endcase
        return r;
    endfunction

    assign game_status = state;

    // Captured board legality: every field below 4 and no value repeated
    always_comb begin
        logic [3:0] seen;
        logic [2:0] t;
        seen     = 4'b0000;
        board_ok = 1'b1;
        zero_pos = 2'd0;
        t        = 3'd0;
        for (int i = 0; i < 4; i++) begin
            t = tile_at(board_out, 2'(i));
            if (t[2] || seen[t[1:0]]) begin
                board_ok = 1'b0;
            end
            seen[t[1:0]] = 1'b1;
            if (t == 3'd0) begin
                zero_pos = 2'(i);
            end
        end
    end

    // Neighbour selection for the requested blank movement (row = bit1, col = bit0)
    always_comb begin
        move_legal = 1'b0;
        target_pos = blank_pos;
        case (move_dir)
            2'b00: begin
                move_legal = blank_pos[1];
                target_pos = {1'b0, blank_pos[0]};
            end
            2'b01: begin
                move_legal = ~blank_pos[1];
                target_pos = {1'b1, blank_pos[0]};
            end
            2'b10: begin
                move_legal = blank_pos[0];
                target_pos = {blank_pos[1], 1'b0};
            end
            default: begin
                move_legal = ~blank_pos[0];
                target_pos = {blank_pos[1], 1'b1};
            end
        endcase
        moved_board = set_tile(set_tile(board_out, blank_pos, tile_at(board_out, target_pos)),
                               target_pos, 3'd0);
        next_count  = (move_count == {CNT_W{1'b1}}) ? move_count : move_count + CNT_W'(1);
    end

    // Game state machine with registered board, counter and pulse outputs
    always_ff @(posedge clk_d) begin
        if (rst) begin
            state       <= CHOSE_BOARD;
            board_out   <= SOLVED;
            move_count  <= '0;
            blank_pos   <= 2'd0;
            move_accept <= 1'b0;
            move_reject <= 1'b0;
            win         <= 1'b0;
            board_err   <= 1'b0;
        end else begin
            move_accept <= 1'b0;
            move_reject <= 1'b0;
            win         <= 1'b0;
            board_err   <= 1'b0;
            case (state)
                CHOSE_BOARD: begin
                    board_out <= board_in;
                    if (start) begin
                        state <= GAME_INITIAL;
                    end
                end
                GAME_INITIAL: begin
                    if (!board_ok) begin
                        board_err <= 1'b1;
                        board_out <= SOLVED;
                        state     <= CHOSE_BOARD;
                    end else begin
                        blank_pos  <= zero_pos;
                        move_count <= '0;
                        if (board_out == SOLVED) begin
                            state <= WINNED;
                            win   <= 1'b1;
                        end else begin
                            state <= GAMING;
                        end
                    end
                end
                GAMING: begin
                    if (quit) begin
                        state <= CHOSE_BOARD;
                    end else if (move_valid) begin
                        if (move_legal) begin
                            board_out   <= moved_board;
                            blank_pos   <= target_pos;
                            move_count  <= next_count;
                            move_accept <= 1'b1;
                            if (moved_board == SOLVED) begin
                                state <= WINNED;
                                win   <= 1'b1;
                            end
                        end else begin
                            move_reject <= 1'b1;
                        end
                    end
                end
                WINNED: begin
                    if (quit || start) begin
                        state <= CHOSE_BOARD;
                    end
                end
                default: begin
                    state <= CHOSE_BOARD;
                end
            endcase
        end
    end

endmodule
